// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter that funnels NREQ writeback requesters into the single
// register-file write port through a one-cycle commit stage, plus a busy scoreboard.
module grf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int PTRW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [32*NREQ-1:0] req_pc,
  output logic [NREQ-1:0]    req_ready,
  input  logic               rsv_valid,
  input  logic [4:0]         rsv_addr,
  output logic               grf_we,
  output logic [4:0]         grf_waddr,
  output logic [31:0]        grf_wd,
  output logic [31:0]        grf_pc,
  output logic [31:0]        busy,
  output logic [15:0]        commit_cnt
);

  // Handshake: requester i transfers on an edge where req_valid[i] & req_ready[i].
  // req_ready is one-hot or zero, may depend on req_valid in the same cycle, and
  // a requester keeps addr/data/pc stable from valid until ready.

  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] ptr_nxt;
  logic [PTRW-1:0] gidx;
  logic [NREQ-1:0] grant;
  logic            found;
  logic            hs;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;
  logic [31:0]     sel_pc;
  logic [31:0]     busy_nxt;

  // Scan distances 0..NREQ-1 from rr_ptr; the first valid requester wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    if (rst && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[i] &&
              ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NREQ))) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            gidx     = PTRW'(i);
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign hs        = found;
  assign ptr_nxt   = (gidx == PTRW'(NREQ - 1)) ? '0 : gidx + PTRW'(1);

  // One-hot AND-OR mux of the granted requester's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_pc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_addr = sel_addr | ({5{grant[i]}}  & req_addr[5*i +: 5]);
      sel_data = sel_data | ({32{grant[i]}} & req_data[32*i +: 32]);
      sel_pc   = sel_pc   | ({32{grant[i]}} & req_pc[32*i +: 32]);
    end
  end

  // Clear before set so a reservation landing on the commit edge survives.
  always_comb begin
    busy_nxt = busy;
    if (grf_we) busy_nxt[grf_waddr] = 1'b0;
    if (rsv_valid && (rsv_addr != 5'd0)) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      grf_we     <= 1'b0;
      grf_waddr  <= '0;
      grf_wd     <= '0;
      grf_pc     <= '0;
      busy       <= '0;
      commit_cnt <= '0;
    end else begin
      grf_we <= hs && (sel_addr != 5'd0);
      if (hs) begin
        rr_ptr    <= ptr_nxt;
        grf_waddr <= sel_addr;
        grf_wd    <= sel_data;
        grf_pc    <= sel_pc;
      end
      busy <= busy_nxt;
      if (grf_we) commit_cnt <= commit_cnt + 16'd1;
    end
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
Shares the single register-file write port between NREQ writeback requesters, e.g. ALU writeback, multiply/divide result and load data. Requesters use a valid/ready handshake. Grants are round-robin, and the selected write is registered into a one-cycle commit stage that drives the register file's WE/wAddr/WD/PC inputs. A per-register busy scoreboard is set at instruction issue and cleared at commit, so the hazard unit can stall readers of pending destinations.

Parameters:
NREQ, 3, number of writeback requesters (2..8)
PTRW, 2, width of round-robin pointer; must satisfy 2^PTRW >= NREQ

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
hold  input  1  freeze arbitration this cycle
req_valid  input  NREQ  per-requester write request
req_addr  input  5*NREQ  destination register, requester i at [5i+4:5i]
req_data  input  32*NREQ  write data, requester i at [32i+31:32i]
req_pc  input  32*NREQ  PC of producing instruction, for the register-file trace
req_ready  output  NREQ  one-hot grant; handshake completes when valid&ready
rsv_valid  input  1  reserve destination at issue
rsv_addr  input  5  register to reserve
grf_we  output  1  register-file write enable
grf_waddr  output  5  register-file write address
grf_wd  output  32  register-file write data
grf_pc  output  32  register-file trace PC
busy  output  32  scoreboard, bit r = write to $r pending
commit_cnt  output  16  number of commits with grf_we=1, wraps at 2^16

Behaviour:
- Reset (rst=0, asynchronous): grf_we=0, grf_waddr=0, grf_wd=0, grf_pc=0, busy=0, commit_cnt=0, rr_ptr=0. No request is granted while rst=0.
- Arbitration is combinational within the cycle:
  - If hold=1 or no req_valid bit is set, req_ready=0.
  - Otherwise grant the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot or zero and may depend on req_valid the same cycle.
  - Requesters hold addr/data/pc stable while valid and not yet ready.
- Handshake on edge with grant g:
  - rr_ptr <= (g+1) mod NREQ.
  - grf_waddr <= req_addr[g], grf_wd <= req_data[g], grf_pc <= req_pc[g].
  - grf_we <= (req_addr[g] != 0).
- Latency: exactly 1 cycle from handshake to grf_we. The register file writes on the following edge. Sustained throughput is one commit per cycle.
- No handshake (hold=1 or no valid): grf_we <= 0. grf_waddr, grf_wd and grf_pc hold their previous values. rr_ptr is unchanged.
- Address 0: the handshake completes (ready asserted, pointer advances) but grf_we stays 0. busy[0] is always 0, and a reservation of $0 is ignored.
- Scoreboard, evaluated each edge:
  - Clear: if grf_we=1, busy[grf_waddr] <= 0.
  - Set: if rsv_valid=1 and rsv_addr!=0, busy[rsv_addr] <= 1.
  - Same register set and cleared on one edge: set wins, because the new reservation is younger.
  - A commit to a non-busy register is legal and leaves busy unchanged.
  - Reserving an already-busy register leaves it busy. Only one pending write per register is tracked; the issue logic guarantees no WAW overlap.
- commit_cnt increments by 1 on each edge where grf_we=1 and wraps from 16'hFFFF to 0.
- hold does not affect the commit stage: a write already registered still commits while hold=1.
- Reset asserted mid-operation: an in-flight commit is discarded (grf_we forced to 0) and all busy bits clear. Requesters must re-present after reset release.

Test Plan:
- Reset, then a single request: req 1 valid with addr=5, data=32'hDEADBEEF, pc=32'h3004 -> req_ready=3'b010 that cycle. Next cycle grf_we=1, grf_waddr=5, grf_wd=DEADBEEF, grf_pc=3004. Cycle after, grf_we=0 and commit_cnt=1.
- Round-robin fairness: all 3 requesters valid continuously for 6 cycles after reset -> grant order 0,1,2,0,1,2. grf_we=1 on 6 consecutive cycles and commit_cnt=6.
- Address zero: req 0 with addr=0, data=32'h1234 -> req_ready[0]=1 and rr_ptr advances to 1. grf_we stays 0, busy[0]=0 and commit_cnt is unchanged.
- Scoreboard: rsv addr=8 -> busy[8]=1 next cycle. Commit addr=8 -> busy[8]=0 after the commit edge. On the same edge as a commit of $9, reserve $9 -> busy[9]=1 (set wins).
- Hold: req 2 valid with hold=1 for 3 cycles -> req_ready=0 and grf_we=0 during hold, pointer unchanged. When hold drops, req 2 is granted and commits 1 cycle later. A commit registered on the cycle before hold rose still completes.
- Asynchronous reset mid-stream: pull rst low between edges while grf_we=1 and busy=32'h0000_0100 -> grf_we=0, busy=0 and commit_cnt=0 immediately, without waiting for a clock edge.
